// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart transmit arbiter.
// Optional statistics are enabled with UART_ARB_STATS_EN.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

  localparam int STAT_W = 16;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first requester strictly after last_ptr,
// wrapping modulo N (rotate, priority-find, unrotate).
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             pos;

  always_comb begin
    dbl = {req, req};
    rot = dbl[int'(last_ptr) + 1 +: N];
    any = 1'b0;
    pos = 0;
    // Scan downwards so the lowest rotated offset wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        pos = (int'(last_ptr) + 1 + k) % N;
      end
    end
    grant_idx = IW'(pos);
    grant     = any ? (N'(1) << pos) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart transmitter between NUM_REQ byte sources with packet locking.
// Define UART_ARB_STATS_EN to add per-requester byte counters.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_BITS    = 8,
  parameter  int MAX_BURST    = 16,
  parameter  int BUSY_TIMEOUT = 16,
  localparam int IW           = clog2_min1(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [IW-1:0]                  grant_id,
  output logic                           grant_active,
  output logic [DATA_BITS-1:0]           uart_tx_data,
  output logic                           uart_tx_start,
  input  logic                           uart_tx_busy,
  output logic                           err_timeout
`ifdef UART_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]      stat_bytes,
  input  logic                           stat_clr
`endif
);

  localparam int TW = clog2_min1(BUSY_TIMEOUT + 1);

  arb_state_t     state;
  arb_state_t     state_nxt;
  logic [IW-1:0]  rr_ptr;
  logic           pkt_last;
  logic [7:0]     burst_cnt;
  logic [TW-1:0]  tmo_cnt;

  logic [NUM_REQ-1:0]   pick_grant;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 idle_go;
  logic                 tmo_hit;
  logic                 busy_tmo;
  logic                 done_evt;
  logic                 keep;
  logic [DATA_BITS-1:0] pick_data;
  logic [DATA_BITS-1:0] own_data;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req       (req_valid),
    .last_ptr  (rr_ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  always_comb begin
    pick_data = req_data[int'(pick_idx)*DATA_BITS +: DATA_BITS];
    own_data  = req_data[int'(grant_id)*DATA_BITS +: DATA_BITS];
    idle_go   = (state == IDLE) && pick_any && !uart_tx_busy;
    tmo_hit   = tmo_cnt == TW'(BUSY_TIMEOUT - 1);
    busy_tmo  = (state == WAIT_BUSY) && !uart_tx_busy && tmo_hit;
    done_evt  = (state == WAIT_DONE) && !uart_tx_busy;
    keep      = req_valid[grant_id] && !pkt_last
             && (burst_cnt < 8'(MAX_BURST));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (idle_go) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (uart_tx_busy) state_nxt = WAIT_DONE;
        else if (tmo_hit) state_nxt = IDLE;
      end
      WAIT_DONE: if (done_evt) state_nxt = keep ? LAUNCH : IDLE;
    endcase
  end

  always_comb begin
    uart_tx_start = (state == LAUNCH);
    req_ready     = '0;
    if (state == LAUNCH) req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= IW'(NUM_REQ - 1);
      grant_id     <= '0;
      grant_active <= 1'b0;
      uart_tx_data <= '0;
      pkt_last     <= 1'b0;
      burst_cnt    <= '0;
      tmo_cnt      <= '0;
      err_timeout  <= 1'b0;
    end else begin
      if (idle_go) begin
        grant_id     <= pick_idx;
        uart_tx_data <= pick_data;
        pkt_last     <= req_last[pick_idx];
        grant_active <= 1'b1;
      end
      if (state == LAUNCH) begin
        burst_cnt <= burst_cnt + 8'd1;
        tmo_cnt   <= '0;
      end
      if (state == WAIT_BUSY && !uart_tx_busy && !tmo_hit)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (busy_tmo) err_timeout <= 1'b1;
      if (done_evt && keep) begin
        uart_tx_data <= own_data;
        pkt_last     <= req_last[grant_id];
      end
      // Lock release: timeout drop or end of packet/burst/valid.
      if (busy_tmo || (done_evt && !keep)) begin
        rr_ptr       <= grant_id;
        burst_cnt    <= '0;
        grant_active <= 1'b0;
      end
    end
  end

`ifdef UART_ARB_STATS_EN
  logic [STAT_W-1:0] stat_cur;

  assign stat_cur = stat_bytes[int'(grant_id)*STAT_W +: STAT_W];

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_bytes <= '0;
    end else if (state == WAIT_BUSY && uart_tx_busy && stat_cur != '1) begin
      stat_bytes[int'(grant_id)*STAT_W +: STAT_W] <= stat_cur + 1'b1;
    end
  end
`endif

endmodule
